// File: rtl/fa_drv_pkg.sv
// Shared types and constants for the PMOD full-adder vector driver.
// Vector layout is {a, b, cin} with a in the MSB.
package fa_drv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  localparam logic [2:0] VEC_LAST = 3'd7;
  localparam int A_BIT   = 2;
  localparam int B_BIT   = 1;
  localparam int CIN_BIT = 0;

  function automatic logic maj3(input logic x, input logic y,
                                input logic z);
    return (x & y) | (y & z) | (x & z);
  endfunction

endpackage

// File: rtl/fa_ref_model.sv
// Combinational golden full adder used as the comparison reference.
// Produces {cout, sum} for one {a, b, cin} vector.
module fa_ref_model
  import fa_drv_pkg::*;
(
  input  logic [2:0] vec_i,
  output logic       sum_o,
  output logic       cout_o
);

  logic a, b, c;

  assign a = vec_i[A_BIT];
  assign b = vec_i[B_BIT];
  assign c = vec_i[CIN_BIT];

  assign sum_o  = a ^ b ^ c;
  assign cout_o = maj3(a, b, c);

endmodule

// File: rtl/fa_vector_driver.sv
// Drives all 8 full-adder vectors to a PMOD target and checks its replies.
// Define FA_DRV_SYNC_EN to route sense pins through 2-flop synchronizers.
module fa_vector_driver
  import fa_drv_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             drv_a,
  output logic             drv_b,
  output logic             drv_cin,
  input  logic             sense_sum,
  input  logic             sense_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       first_fail,
  output logic [2:0]       vec_idx,
  output logic [3:0]       led
);

  localparam int TW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [2:0]       vec_q, vec_d;
  logic [2:0]       drv_q, drv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [2:0]       ff_q, ff_d;

  logic             sum_cmp, cout_cmp;
  logic             gold_sum, gold_cout;
  logic             mism;
  logic [ERR_W-1:0] err_nxt;

`ifdef FA_DRV_SYNC_EN
  if (SETTLE_CYCLES < 3) begin : g_settle_chk
    $error("SETTLE_CYCLES must be >= 3 with FA_DRV_SYNC_EN");
  end

  logic [1:0] sum_sync_q, cout_sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_sync_q  <= '0;
      cout_sync_q <= '0;
    end else begin
      sum_sync_q  <= {sum_sync_q[0], sense_sum};
      cout_sync_q <= {cout_sync_q[0], sense_cout};
    end
  end

  assign sum_cmp  = sum_sync_q[1];
  assign cout_cmp = cout_sync_q[1];
`else
  if (SETTLE_CYCLES < 1) begin : g_settle_chk
    $error("SETTLE_CYCLES must be >= 1");
  end

  assign sum_cmp  = sense_sum;
  assign cout_cmp = sense_cout;
`endif

  fa_ref_model u_ref (
    .vec_i  (drv_q),
    .sum_o  (gold_sum),
    .cout_o (gold_cout)
  );

  assign mism = (sum_cmp != gold_sum) | (cout_cmp != gold_cout);
  assign err_nxt =
    (mism && (err_q != '1)) ? err_q + 1'b1 : err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      vec_q   <= '0;
      drv_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      vec_q   <= vec_d;
      drv_q   <= drv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_DRIVE;
      ST_DRIVE:  state_d = ST_SETTLE;
      ST_SETTLE: if (timer_q == '0) state_d = ST_CHECK;
      ST_CHECK:
        state_d = (vec_q == VEC_LAST) ? ST_DONE : ST_DRIVE;
      ST_DONE:   if (!start) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    timer_d = timer_q;
    vec_d   = vec_q;
    drv_d   = drv_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ff_d    = ff_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          vec_d  = '0;
          drv_d  = '0;
          err_d  = '0;
          ff_d   = '0;
          done_d = 1'b0;
          pass_d = 1'b0;
          busy_d = 1'b1;
        end
      end
      ST_DRIVE:  timer_d = TIMER_LOAD;
      ST_SETTLE: if (timer_q != '0) timer_d = timer_q - 1'b1;
      ST_CHECK: begin
        err_d = err_nxt;
        // first_fail latches only on the run's first mismatch
        if (mism && (err_q == '0)) ff_d = vec_q;
        if (vec_q == VEC_LAST) begin
          done_d = 1'b1;
          busy_d = 1'b0;
          pass_d = (err_nxt == '0);
          drv_d  = '0;
        end else begin
          vec_d = vec_q + 3'd1;
          drv_d = vec_q + 3'd1;
        end
      end
      default: ;
    endcase
  end

  assign drv_a      = drv_q[A_BIT];
  assign drv_b      = drv_q[B_BIT];
  assign drv_cin    = drv_q[CIN_BIT];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;
  assign vec_idx    = vec_q;
  assign led        = {|err_q, busy_q, done_q, pass_q};

endmodule

// File: tb/tb_fa_vector_driver.sv
// Bench for fa_vector_driver: loopback target with selectable faults,
// run-level behavioural model checked every cycle, plus literal pins.
module tb_fa_vector_driver;

  localparam int S   = 4;
  localparam int P   = S + 2;
  localparam int RUN = 8 * P;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       drv_a, drv_b, drv_cin;
  logic       sense_sum, sense_cout;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] first_fail, vec_idx;
  logic [3:0] led;

  logic       drv_a2, drv_b2, drv_cin2;
  logic       sense_sum2, sense_cout2;
  logic       busy2, done2, pass2;
  logic [1:0] err_count2;
  logic [2:0] first_fail2, vec_idx2;
  logic [3:0] led2;

  int fault = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Target: {cout, sum}; 1 = sum stuck-at-0, 2 = cout inverted
  function automatic logic [1:0] target(input logic [2:0] v,
                                        input int f);
    logic [1:0] s;
    s = 2'({1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]});
    if (f == 1) s[0] = 1'b0;
    if (f == 2) s[1] = ~s[1];
    return s;
  endfunction

  assign {sense_cout, sense_sum} =
    target({drv_a, drv_b, drv_cin}, fault);
  assign {sense_cout2, sense_sum2} =
    target({drv_a2, drv_b2, drv_cin2}, fault);

  fa_vector_driver #(.SETTLE_CYCLES(S), .ERR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .drv_a(drv_a), .drv_b(drv_b), .drv_cin(drv_cin),
    .sense_sum(sense_sum), .sense_cout(sense_cout),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail(first_fail),
    .vec_idx(vec_idx), .led(led)
  );

  fa_vector_driver #(.SETTLE_CYCLES(S), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start),
    .drv_a(drv_a2), .drv_b(drv_b2), .drv_cin(drv_cin2),
    .sense_sum(sense_sum2), .sense_cout(sense_cout2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err_count2), .first_fail(first_fail2),
    .vec_idx(vec_idx2), .led(led2)
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: a run is just "edges since acceptance"; results follow
  bit m_run, m_any, m_hold;
  int m_cyc;
  bit m_mm [8];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run  = 0;
      m_any  = 0;
      m_hold = 0;
      m_cyc  = 0;
    end else if (m_run) begin
      m_cyc++;
      if (m_cyc == RUN) begin
        m_run  = 0;
        m_any  = 1;
        m_hold = 1;
      end
    end else if (m_hold) begin
      if (!start) m_hold = 0;
    end else if (start) begin
      m_run = 1;
      m_cyc = 0;
      for (int v = 0; v < 8; v++)
        m_mm[v] = target(3'(v), fault) != target(3'(v), 0);
    end
  end

  function automatic int exp_err(input int cyc);
    int e = 0;
    for (int v = 0; v < 8; v++)
      if ((v + 1) * P <= cyc && m_mm[v]) e++;
    return (e > 15) ? 15 : e;
  endfunction

  function automatic int exp_ff(input int cyc);
    for (int v = 0; v < 8; v++)
      if ((v + 1) * P <= cyc && m_mm[v]) return v;
    return 0;
  endfunction

  always @(negedge clk) begin
    int e_drv, e_vec, e_err, e_ff;
    bit e_busy, e_done, e_pass;
    if (!rst) begin
      if (m_run) begin
        e_vec  = m_cyc / P;
        e_drv  = e_vec;
        e_busy = 1;
        e_done = 0;
        e_pass = 0;
        e_err  = exp_err(m_cyc);
        e_ff   = exp_ff(m_cyc);
      end else if (m_any) begin
        e_vec  = 7;
        e_drv  = 0;
        e_busy = 0;
        e_done = 1;
        e_err  = exp_err(RUN);
        e_ff   = exp_ff(RUN);
        e_pass = (e_err == 0);
      end else begin
        e_vec = 0; e_drv = 0; e_busy = 0; e_done = 0;
        e_pass = 0; e_err = 0; e_ff = 0;
      end
      check("drv", {drv_a, drv_b, drv_cin}, e_drv);
      check("vec_idx", vec_idx, e_vec);
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("pass", pass, e_pass);
      check("err_count", err_count, e_err);
      check("first_fail", first_fail, e_ff);
      check("led", led, {e_err != 0, e_busy, e_done, e_pass});
    end
  end

  // One run: start low for an edge, then high; count edges to done
  task automatic run_and_wait(input bit hold, output int n);
    @(negedge clk) start = 1'b0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    if (!hold) begin
      @(negedge clk) start = 1'b0;
    end
    while (!done && n < 400) begin
      @(posedge clk);
      n++;
      #1;
    end
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_drv", {drv_a, drv_b, drv_cin}, 0);
    check("rst_err", err_count, 0);
    rst = 1'b0;

    fault = 0;
    run_and_wait(0, n);
    check("good_latency", n, 48);
    check("good_pass", pass, 1);
    check("good_err", err_count, 0);

    fault = 1;
    run_and_wait(0, n);
    check("stuck_latency", n, 48);
    check("stuck_err", err_count, 4);
    check("stuck_ff", first_fail, 1);
    check("stuck_pass", pass, 0);
    check("stuck_led", led, 4'b1010);

    fault = 2;
    run_and_wait(1, n);
    check("inv_err", err_count, 8);
    check("inv_ff", first_fail, 0);
    check("inv_pass", pass, 0);
    check("inv_sat_err2", err_count2, 3);
    check("inv_done2", done2, 1);
    repeat (20) @(negedge clk);
    check("hold_done", done, 1);
    check("hold_busy", busy, 0);

    fault = 0;
    run_and_wait(0, n);
    check("rerun_latency", n, 48);
    check("rerun_err", err_count, 0);
    check("rerun_pass", pass, 1);

    @(negedge clk) start = 1'b0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    check("mid_vec", vec_idx, 5);
    check("mid_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_drv", {drv_a, drv_b, drv_cin}, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_vec", vec_idx, 0);
    @(negedge clk) rst = 1'b0;

    run_and_wait(0, n);
    check("post_rst_latency", n, 48);
    check("post_rst_pass", pass, 1);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
